// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit, data/ready back from memory.
interface ifetch_unit_if #(
    parameter int IMEM_AW = 14
) ();
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: PC register, req/ready fetch FSM and next-PC selection for the single-cycle CPU.
// Define IFETCH_ALIGN_CHECK_EN to halt with align_err on a misaligned next PC instead of masking it.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic          clock,
    input  logic          reset,
    ifetch_unit_if.master imem,
    output logic [31:0]   Instruction,
    output logic          instr_valid,
    output logic [31:0]   PC_plus_4,
    input  logic [31:0]   Add_result,
    input  logic [31:0]   Read_data_1,
    input  logic          Zero,
    input  logic          Branch,
    input  logic          nBranch,
    input  logic          Jmp,
    input  logic          Jal,
    input  logic          Jrn,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic          align_err,
`endif
    output logic [31:0]   link_addr
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        req;
    logic [31:0] target;
    logic [31:0] next_pc;

    function automatic logic [31:0] select_target(
        input logic [31:0] pc4, input logic [31:0] instr, input logic [31:0] add_res,
        input logic [31:0] rs, input logic zero, input logic beq, input logic bne,
        input logic jmp, input logic jal, input logic jr);
        logic [31:0] t;
        if (jr)
            t = rs;
        else if (jmp || jal)
            t = {pc4[31:28], instr[25:0], 2'b00};
        else if ((beq && zero) || (bne && !zero))
            t = add_res;
        else
            t = pc4;
        return t;
    endfunction

    assign PC_plus_4      = pc + 32'd4;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc[IMEM_AW+1:2];

    always_comb begin
        target = select_target(PC_plus_4, Instruction, Add_result, Read_data_1,
                               Zero, Branch, nBranch, Jmp, Jal, Jrn);
`ifdef IFETCH_ALIGN_CHECK_EN
        next_pc = target;
`else
        next_pc = target & ~32'h3;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            Instruction <= 32'h0;
            link_addr   <= 32'h0;
            instr_valid <= 1'b0;
            req         <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            align_err   <= 1'b0;
`endif
        end else begin
            case (state)
                // First REQ cycle after reset only raises the request; ready is ignored until then.
                S_REQ: begin
                    if (!req) begin
                        req <= 1'b1;
                    end else if (imem.imem_ready) begin
                        Instruction <= imem.imem_rdata;
                        req         <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_ready) begin
                        Instruction <= imem.imem_rdata;
                        req         <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    instr_valid <= 1'b0;
                    if (Jal)
                        link_addr <= PC_plus_4;
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        align_err <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        pc    <= next_pc;
                        req   <= 1'b1;
                        state <= S_REQ;
                    end
`else
                    pc    <= next_pc;
                    req   <= 1'b1;
                    state <= S_REQ;
`endif
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: table of next-PC vectors plus hand sequences for wait/reset/alignment.
module tb_ifetch_unit;

    localparam int IMEM_AW = 14;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] add;
        logic [31:0] rd1;
        logic        zero;
        logic        br;
        logic        nbr;
        logic        jmp;
        logic        jal;
        logic        jrn;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic [31:0] PC_plus_4;
    logic [31:0] Add_result = '0;
    logic [31:0] Read_data_1 = '0;
    logic        Zero = 1'b0, Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jrn = 1'b0;
    logic [31:0] link_addr;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cur_pc = 32'h0;
    logic [31:0] exp_link = 32'h0;
    vec_t vecs[11];

    ifetch_unit_if #(.IMEM_AW(IMEM_AW)) imem_bus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(IMEM_AW)) dut (
        .clock(clock), .reset(reset), .imem(imem_bus),
        .Instruction(Instruction), .instr_valid(instr_valid), .PC_plus_4(PC_plus_4),
        .Add_result(Add_result), .Read_data_1(Read_data_1), .Zero(Zero),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn),
`ifdef IFETCH_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .link_addr(link_addr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] waddr(input logic [31:0] byte_addr);
        return {18'd0, byte_addr[15:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout: got imem_req=%b expected 1", imem_bus.imem_req);
        end
    endtask

    task automatic drive_ctrl(input vec_t v);
        Add_result = v.add; Read_data_1 = v.rd1; Zero = v.zero;
        Branch = v.br; nBranch = v.nbr; Jmp = v.jmp; Jal = v.jal; Jrn = v.jrn;
    endtask

    task automatic clear_ctrl();
        Add_result = '0; Read_data_1 = '0; Zero = 0; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0;
    endtask

    task automatic do_instr(input vec_t v, input int delay, input string tag);
        logic [31:0] a0;
        wait_req();
        a0 = {18'd0, imem_bus.imem_addr};
        for (int i = 0; i < delay; i++) begin
            imem_bus.imem_ready = 1'b0;
            tick();
            check({tag, "_wait_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
            check({tag, "_wait_addr"}, {18'd0, imem_bus.imem_addr}, a0);
            check({tag, "_wait_valid"}, {31'd0, instr_valid}, 32'd0);
        end
        imem_bus.imem_rdata = v.instr;
        imem_bus.imem_ready = 1'b1;
        drive_ctrl(v);
        tick();
        imem_bus.imem_ready = 1'b0;
        check({tag, "_exec_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_exec_instr"}, Instruction, v.instr);
        check({tag, "_exec_pc4"}, PC_plus_4, v.pc + 32'd4);
        if (v.jal) exp_link = v.pc + 32'd4;
        tick();
        clear_ctrl();
        check({tag, "_next_addr"}, {18'd0, imem_bus.imem_addr}, waddr(v.exp_pc));
        check({tag, "_next_pc4"}, PC_plus_4, v.exp_pc + 32'd4);
        check({tag, "_link"}, link_addr, exp_link);
        check({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
        cur_pc = v.exp_pc;
    endtask

    task automatic jump_to(input logic [31:0] target);
        vec_t s;
        s = '{pc: cur_pc, instr: 32'h0, add: 32'h0, rd1: target, zero: 0, br: 0, nbr: 0,
              jmp: 0, jal: 0, jrn: 1, exp_pc: target};
        do_instr(s, 0, "setup");
    endtask

    initial begin
        vec_t va;
        vecs[0]  = '{32'h0000_0040, 32'h1000_0010, 32'h0000_0100, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0100};
        vecs[1]  = '{32'h0000_0040, 32'h1000_0010, 32'h0000_0100, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0000_0044};
        vecs[2]  = '{32'h0000_0040, 32'h1400_0010, 32'h0000_0100, 32'h0, 0, 0, 1, 0, 0, 0, 32'h0000_0100};
        vecs[3]  = '{32'h0000_0040, 32'h1400_0010, 32'h0000_0100, 32'h0, 1, 0, 1, 0, 0, 0, 32'h0000_0044};
        vecs[4]  = '{32'h1000_0010, 32'h0C00_0020, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h1000_0080};
        vecs[5]  = '{32'h1000_0080, 32'h03E0_0008, 32'h0, 32'h1000_0014, 0, 0, 0, 0, 0, 1, 32'h1000_0014};
        vecs[6]  = '{32'h2000_0000, 32'h0BFF_FFFF, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h2FFF_FFFC};
        vecs[7]  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0000};
        vecs[8]  = '{32'h0000_0080, 32'h0800_0010, 32'h0, 32'h0000_0200, 0, 0, 0, 1, 0, 1, 32'h0000_0200};
        vecs[9]  = '{32'h3000_0100, 32'h0800_0010, 32'h0000_0500, 32'h0, 1, 1, 0, 1, 0, 0, 32'h3000_0040};
        vecs[10] = '{32'h0000_0040, 32'h1000_0010, 32'h0000_0300, 32'h0, 1, 1, 1, 0, 0, 0, 32'h0000_0300};

        imem_bus.imem_rdata = 32'h0;
        imem_bus.imem_ready = 1'b0;
        repeat (3) tick();
        check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_link", link_addr, 32'h0);
        check("rst_addr", {18'd0, imem_bus.imem_addr}, 32'h0);
        check("rst_pc4", PC_plus_4, 32'h4);

        // Ready tied high: back-to-back two-cycle fetches at consecutive word addresses.
        reset = 1'b0;
        imem_bus.imem_ready = 1'b1;
        wait_req();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream%0d_addr", k), {18'd0, imem_bus.imem_addr}, k);
            check($sformatf("stream%0d_req_valid", k), {30'd0, imem_bus.imem_req, instr_valid}, 32'd2);
            check($sformatf("stream%0d_pc4", k), PC_plus_4, 32'd4 * k + 32'd4);
            tick();
            check($sformatf("stream%0d_pulse", k), {30'd0, imem_bus.imem_req, instr_valid}, 32'd1);
            tick();
        end
        imem_bus.imem_ready = 1'b0;
        cur_pc = 32'h10;

        // Reset while waiting: outstanding fetch abandoned, late ready ignored.
        tick();
        tick();
        check("rwait_req_held", {31'd0, imem_bus.imem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rwait_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("rwait_valid", {31'd0, instr_valid}, 32'd0);
        check("rwait_addr", {18'd0, imem_bus.imem_addr}, 32'h0);
        check("rwait_pc4", PC_plus_4, 32'h4);
        imem_bus.imem_rdata = 32'h2000_ABCD;
        imem_bus.imem_ready = 1'b1;
        tick();
        check("rwait_late_ignored", {30'd0, imem_bus.imem_req, instr_valid}, 32'd2);
        tick();
        imem_bus.imem_ready = 1'b0;
        check("rwait_exec", {30'd0, imem_bus.imem_req, instr_valid}, 32'd1);
        check("rwait_instr", Instruction, 32'h2000_ABCD);
        tick();
        check("rwait_next_addr", {18'd0, imem_bus.imem_addr}, 32'h1);
        cur_pc = 32'h4;
        exp_link = 32'h0;

        for (int i = 0; i < 11; i++) begin
            jump_to(vecs[i].pc);
            do_instr(vecs[i], (i % 2 == 0) ? 3 : i % 3, $sformatf("vec%0d", i));
        end

        // Misaligned jr target.
        jump_to(32'h0000_0040);
        va = '{32'h0000_0040, 32'h03E0_0008, 32'h0, 32'h0000_0102, 0, 0, 0, 0, 0, 1, 32'h0000_0100};
`ifdef IFETCH_ALIGN_CHECK_EN
        wait_req();
        imem_bus.imem_ready = 1'b1;
        drive_ctrl(va);
        tick();
        imem_bus.imem_ready = 1'b0;
        tick();
        clear_ctrl();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("align_err%0d", k), {31'd0, align_err}, 32'd1);
            check($sformatf("align_halt%0d", k), {30'd0, imem_bus.imem_req, instr_valid}, 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("align_err_cleared", {31'd0, align_err}, 32'd0);
`else
        do_instr(va, 0, "align_mask");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
